alu_md: RTL and testbench
=========================

Name: alu_md

Overview:
- Parametrised next-generation execute-stage unit for the MIPS datapath.
- Combines a single-cycle combinational integer ALU, now with a signed-overflow flag, with an iterative multi-cycle multiply/divide unit.
- The multiply/divide unit owns the HI/LO registers.
- The pipeline stalls on Busy when a later MD op or an mfhi/mflo needs the result.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two and at least 8.
- SHW, $clog2(WIDTH), number of shift-amount bits taken from A.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- A  input  WIDTH  operand A; shift amount in A[SHW-1:0].
- B  input  WIDTH  operand B.
- Op  input  4  ALU operation select.
- Out  output  WIDTH  combinational ALU result.
- Zero  output  1  high when Out == 0.
- Ovf  output  1  signed overflow; valid for ADD and SUB only, 0 otherwise.
- MdOp  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- MdStart  input  1  qualifies MdOp for one cycle.
- Busy  output  1  a multiply/divide operation is in flight.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- ALU path is purely combinational, with no latency.
- Op encodings:
  - 0 ADD, 1 SUB, 2 AND, 3 OR
  - 4 SRL B>>A[SHW-1:0], 5 SRA, 6 SLL
  - 7 SLT (signed), 8 SLTU, 9 NOR, 10 XOR
  - 11 pass A, 12 pass B
  - 13-15 drive Out = 0
- Shift amount uses only A[SHW-1:0]; upper bits of A are ignored.
- Ovf for ADD: A[W-1] == B[W-1] and Out[W-1] != A[W-1]. For SUB: A[W-1] != B[W-1] and Out[W-1] != A[W-1].
- Reset: HI = 0, LO = 0, Busy = 0, internal counter and state = IDLE. This applies asynchronously, including mid-operation; any partial result is discarded.
- FSM states:
  - IDLE:
    - MdStart with MdOp 1-4 latches A, B, the op and the operand signs, then goes to RUN, with Busy = 1 from the next cycle.
    - MdStart with MTHI writes HI <= A at that edge, stays in IDLE, Busy stays 0; MTLO likewise writes LO.
    - NOP or reserved MdOp: no effect.
  - RUN:
    - Processes one bit per cycle on operand magnitudes: shift-add for multiply, restoring for divide.
    - Counter runs WIDTH down to 1, then goes to DONE.
  - DONE:
    - Applies sign correction and writes HI/LO at this edge, then returns to IDLE.
    - Busy = 0 from that edge onward.
- Latency:
  - Start accepted at edge k.
  - Busy = 1 for edges k+1 through k+WIDTH+1.
  - HI/LO updated, and Busy falls, at edge k+WIDTH+2.
  - Total latency is WIDTH+2 cycles (34 at default width) for all four ops.
- Results:
  - MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
- Divide boundaries:
  - Divide by zero: LO = all ones, HI = dividend. Takes full latency, no exception.
  - Signed MIN / -1: LO = MIN, HI = 0.
- MdStart while Busy = 1 is ignored entirely, including MTHI/MTLO; HI/LO and the running operation are unaffected. Holding the request until Busy = 0 is the pipeline's job.
- HI/LO hold their values during RUN and change only at DONE or on MTHI/MTLO.
- ALU path is fully usable while Busy = 1.

Decomposition:
- Shared package contents:
  - ALU Op encodings
  - MdOp encodings
  - FSM state enum (IDLE/RUN/DONE)
- One natural sub-module: md_unit, containing the FSM, counter, HI/LO and datapath.
- alu_md instantiates the combinational ALU logic plus md_unit.

Test Plan:
- ALU ops at WIDTH=32:
  - ADD 0x7FFFFFFF+1 -> Out = 0x80000000, Ovf = 1.
  - SUB 5-5 -> Out = 0, Zero = 1.
  - SRA 0x80000000 by A = 0x24 (uses 4) -> 0xF8000000.
  - SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
- MULT:
  - MULT -3 × 7 -> Busy = 1 for exactly 33 cycles after start; at latency 34 HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
  - MULTU 0xFFFFFFFF² -> HI = 0xFFFFFFFE, LO = 0x00000001.
- Division:
  - DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU 7 / 0 -> LO = 0xFFFFFFFF, HI = 7.
  - DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- Busy interference:
  - MULT running, then MTHI 0x1234 and a second MULT asserted mid-operation -> both ignored; final HI/LO equal the first product only.
- MTHI/MTLO when idle:
  - MTLO 0xABCD -> LO = 0xABCD after one edge, Busy never rises.
- Reset and parametrisation:
  - reset_n low at cycle 10 of a DIV -> immediately Busy = 0, HI = LO = 0; a new DIVU 100 / 7 then gives LO = 14, HI = 2.
  - Repeat MULT/DIV checks at WIDTH=16 -> latency 18 cycles.

Source files
------------

// File: rtl/alu_md_pkg.sv
// rtl/alu_md_pkg.sv - shared encodings for the ALU and the multiply/divide unit
package alu_md_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_SRL   = 4'd4,
    ALU_SRA   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SLT   = 4'd7,
    ALU_SLTU  = 4'd8,
    ALU_NOR   = 4'd9,
    ALU_XOR   = 4'd10,
    ALU_PASSA = 4'd11,
    ALU_PASSB = 4'd12
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/alu_md_md_unit.sv
// rtl/alu_md_md_unit.sv - iterative multiply/divide unit owning HI/LO
module md_unit
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       md_op_i,
  input  logic             md_start_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  md_state_e        state_q, state_d;
  md_op_e           op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, p_hi_q, p_lo_q, hi_q, lo_q;

  logic             start_md, start_mul, start_sgn, is_mul, is_sgn;
  logic [WIDTH-1:0] m_op, step_hi, step_lo, res_hi, res_lo;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic             div_ge, neg_res, neg_rem;
  logic [2*WIDTH-1:0] prod, prod_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? -x : x;
  endfunction

  assign start_md  = md_start_i && (md_op_i >= MD_MULT) && (md_op_i <= MD_DIVU);
  assign start_mul = (md_op_i == MD_MULT) || (md_op_i == MD_MULTU);
  assign start_sgn = (md_op_i == MD_MULT) || (md_op_i == MD_DIV);
  assign is_mul    = (op_q == MD_MULT) || (op_q == MD_MULTU);
  assign is_sgn    = (op_q == MD_MULT) || (op_q == MD_DIV);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= MD_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (start_md) state_d = MD_RUN;
      MD_RUN:  if (cnt_q == '0) state_d = MD_DONE;
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Busy rises one edge after the start is accepted, so the first RUN cycle
  // (counter still at its load value) reports idle; new requests are still refused.
  always_comb begin
    busy_o = 1'b0;
    case (state_q)
      MD_RUN:  busy_o = (cnt_q != CNT_LOAD);
      MD_DONE: busy_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  // One iteration on magnitudes: right-shift add for multiply, restoring divide.
  always_comb begin
    m_op    = is_mul ? mag(a_q, is_sgn) : mag(b_q, is_sgn);
    mul_sum = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, m_op} : '0);
    div_sh  = {p_hi_q, p_lo_q[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, m_op});
    if (is_mul) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], p_lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? WIDTH'(div_sh - {1'b0, m_op}) : div_sh[WIDTH-1:0];
      step_lo = {p_lo_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    neg_res  = is_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    neg_rem  = is_sgn && a_q[WIDTH-1];
    prod     = {p_hi_q, p_lo_q};
    prod_fix = neg_res ? -prod : prod;
    if (is_mul) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (b_q == '0) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = neg_rem ? -p_hi_q : p_hi_q;
      res_lo = neg_res ? -p_lo_q : p_lo_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= MD_NOP;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      p_hi_q <= '0;
      p_lo_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_md) begin
            op_q   <= md_op_e'(md_op_i);
            a_q    <= a_i;
            b_q    <= b_i;
            cnt_q  <= CNT_LOAD;
            p_hi_q <= '0;
            p_lo_q <= start_mul ? mag(b_i, start_sgn) : mag(a_i, start_sgn);
          end else if (md_start_i && (md_op_i == MD_MTHI)) begin
            hi_q <= a_i;
          end else if (md_start_i && (md_op_i == MD_MTLO)) begin
            lo_q <= a_i;
          end
        end
        MD_RUN: begin
          if (cnt_q != '0) begin
            p_hi_q <= step_hi;
            p_lo_q <= step_lo;
            cnt_q  <= cnt_q - CW'(1);
          end
        end
        MD_DONE: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/alu_md.sv
// rtl/alu_md.sv - execute stage: combinational ALU plus multi-cycle multiply/divide
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             Ovf,
  input  logic [2:0]       MdOp,
  input  logic             MdStart,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  logic [WIDTH-1:0] sum, dif, out_c;
  logic [SHW-1:0]   shamt;
  logic             slt, sltu;

  assign sum   = A + B;
  assign dif   = A - B;
  assign shamt = A[SHW-1:0];
  assign slt   = ($signed(A) < $signed(B));
  assign sltu  = (A < B);

  always_comb begin
    out_c = '0;
    case (Op)
      ALU_ADD:   out_c = sum;
      ALU_SUB:   out_c = dif;
      ALU_AND:   out_c = A & B;
      ALU_OR:    out_c = A | B;
      ALU_SRL:   out_c = B >> shamt;
      ALU_SRA:   out_c = $unsigned($signed(B) >>> shamt);
      ALU_SLL:   out_c = B << shamt;
      ALU_SLT:   out_c = {{(WIDTH-1){1'b0}}, slt};
      ALU_SLTU:  out_c = {{(WIDTH-1){1'b0}}, sltu};
      ALU_NOR:   out_c = ~(A | B);
      ALU_XOR:   out_c = A ^ B;
      ALU_PASSA: out_c = A;
      ALU_PASSB: out_c = B;
      default:   out_c = '0;
    endcase
  end

  always_comb begin
    Ovf = 1'b0;
    case (Op)
      ALU_ADD: Ovf = (A[WIDTH-1] == B[WIDTH-1]) && (out_c[WIDTH-1] != A[WIDTH-1]);
      ALU_SUB: Ovf = (A[WIDTH-1] != B[WIDTH-1]) && (out_c[WIDTH-1] != A[WIDTH-1]);
      default: Ovf = 1'b0;
    endcase
  end

  assign Out  = out_c;
  assign Zero = (out_c == '0);

  md_unit #(.WIDTH(WIDTH)) u_md (
    .clk        (clk),
    .reset_n    (reset_n),
    .a_i        (A),
    .b_i        (B),
    .md_op_i    (MdOp),
    .md_start_i (MdStart),
    .busy_o     (Busy),
    .hi_o       (HI),
    .lo_o       (LO)
  );

endmodule

// File: tb/tb_alu_md.sv
// tb/tb_alu_md.sv - scoreboard bench for alu_md at WIDTH 32 and 16
module tb_alu_md;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, out32, hi32, lo32;
  logic [15:0] a16 = '0, b16 = '0, out16, hi16, lo16;
  logic [3:0]  op32 = '0, op16 = '0;
  logic [2:0]  mdop32 = '0, mdop16 = '0;
  logic        start32 = 1'b0, start16 = 1'b0;
  logic        zero32, ovf32, busy32, zero16, ovf16, busy16;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          start;
  } exp_t;
  exp_t q32[$];
  exp_t q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_md #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .A(a32), .B(b32), .Op(op32), .Out(out32),
    .Zero(zero32), .Ovf(ovf32), .MdOp(mdop32), .MdStart(start32),
    .Busy(busy32), .HI(hi32), .LO(lo32)
  );

  alu_md #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .A(a16), .B(b16), .Op(op16), .Out(out16),
    .Zero(zero16), .Ovf(ovf16), .MdOp(mdop16), .MdStart(start16),
    .Busy(busy16), .HI(hi16), .LO(lo16)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  // Monitors: a falling Busy (outside reset) is a completed operation.
  initial begin
    logic bprev;
    int   bcnt;
    exp_t e;
    bprev = 1'b0;
    bcnt  = 0;
    forever begin
      @(negedge clk);
      if (busy32) bcnt++;
      if (bprev && !busy32 && reset_n) begin
        if (q32.size() == 0) begin
          chk("w32 unexpected completion", 32'd1, 32'd0);
        end else begin
          e = q32.pop_front();
          chk({e.name, " HI"}, hi32, e.hi);
          chk({e.name, " LO"}, lo32, e.lo);
          chk({e.name, " latency"}, 32'(cyc - e.start), 32'd34);
          chk({e.name, " busy cycles"}, 32'(bcnt), 32'd33);
        end
      end
      if (!busy32) bcnt = 0;
      bprev = busy32;
    end
  end

  initial begin
    logic bprev;
    int   bcnt;
    exp_t e;
    bprev = 1'b0;
    bcnt  = 0;
    forever begin
      @(negedge clk);
      if (busy16) bcnt++;
      if (bprev && !busy16 && reset_n) begin
        if (q16.size() == 0) begin
          chk("w16 unexpected completion", 32'd1, 32'd0);
        end else begin
          e = q16.pop_front();
          chk({e.name, " HI"}, {16'h0, hi16}, e.hi);
          chk({e.name, " LO"}, {16'h0, lo16}, e.lo);
          chk({e.name, " latency"}, 32'(cyc - e.start), 32'd18);
          chk({e.name, " busy cycles"}, 32'(bcnt), 32'd17);
        end
      end
      if (!busy16) bcnt = 0;
      bprev = busy16;
    end
  end

  task automatic issue(input bit w16, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int start);
    @(negedge clk);
    if (w16) begin
      mdop16 = op; a16 = a[15:0]; b16 = b[15:0]; start16 = 1'b1;
    end else begin
      mdop32 = op; a32 = a; b32 = b; start32 = 1'b1;
    end
    start = cyc + 1;
    @(negedge clk);
    start16 = 1'b0; start32 = 1'b0; mdop16 = '0; mdop32 = '0;
  endtask

  task automatic wait_idle(input bit w16, input string nm);
    int n;
    n = 0;
    while (!(w16 ? busy16 : busy32) && n < 4) begin @(negedge clk); n++; end
    if (!(w16 ? busy16 : busy32)) chk({nm, " busy rise timeout"}, 32'd0, 32'd1);
    n = 0;
    while ((w16 ? busy16 : busy32) && n < 100) begin @(negedge clk); n++; end
    if (w16 ? busy16 : busy32) chk({nm, " busy fall timeout"}, 32'd1, 32'd0);
  endtask

  task automatic md(input bit w16, input logic [2:0] op, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                    input string nm);
    int s;
    exp_t e;
    issue(w16, op, a, b, s);
    e.name = nm; e.hi = ehi; e.lo = elo; e.start = s;
    if (w16) q16.push_back(e); else q32.push_back(e);
    wait_idle(w16, nm);
  endtask

  task automatic alu(input bit w16, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eout, input logic ez,
                     input logic eo, input string nm);
    @(negedge clk);
    if (w16) begin op16 = op; a16 = a[15:0]; b16 = b[15:0]; end
    else begin op32 = op; a32 = a; b32 = b; end
    #1;
    chk({nm, " Out"},  w16 ? {16'h0, out16} : out32, eout);
    chk({nm, " Zero"}, {31'h0, w16 ? zero16 : zero32}, {31'h0, ez});
    chk({nm, " Ovf"},  {31'h0, w16 ? ovf16 : ovf32}, {31'h0, eo});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    exp_t e;
    logic [31:0] hi_keep;

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset busy32", {31'h0, busy32}, 32'd0);
    chk("reset HI32", hi32, 32'd0);
    chk("reset LO32", lo32, 32'd0);
    chk("reset busy16", {31'h0, busy16}, 32'd0);

    alu(0, 4'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, "ADD ovf");
    alu(0, 4'd1,  32'd5,        32'd5,        32'h0,        1, 0, "SUB zero");
    alu(0, 4'd1,  32'h80000000, 32'h1,        32'h7FFFFFFF, 0, 1, "SUB ovf");
    alu(0, 4'd2,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, "AND");
    alu(0, 4'd3,  32'hF0F00000, 32'h0000000F, 32'hF0F0000F, 0, 0, "OR");
    alu(0, 4'd4,  32'h00000024, 32'hF0000000, 32'h0F000000, 0, 0, "SRL");
    alu(0, 4'd5,  32'h00000024, 32'h80000000, 32'hF8000000, 0, 0, "SRA");
    alu(0, 4'd6,  32'h00000008, 32'h00000001, 32'h00000100, 0, 0, "SLL");
    alu(0, 4'd7,  32'hFFFFFFFF, 32'h1,        32'h1,        0, 0, "SLT");
    alu(0, 4'd8,  32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, "SLTU");
    alu(0, 4'd9,  32'h0,        32'h0,        32'hFFFFFFFF, 0, 0, "NOR");
    alu(0, 4'd10, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 0, 0, "XOR");
    alu(0, 4'd11, 32'h12345678, 32'h9,        32'h12345678, 0, 0, "PASSA");
    alu(0, 4'd12, 32'h12345678, 32'h9,        32'h9,        0, 0, "PASSB");
    alu(0, 4'd13, 32'h12345678, 32'h9,        32'h0,        1, 0, "OP13");
    alu(1, 4'd5,  32'h14,       32'h8000,     32'hF800,     0, 0, "w16 SRA");
    alu(1, 4'd0,  32'h7FFF,     32'h1,        32'h8000,     0, 1, "w16 ADD ovf");

    md(0, 3'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "MULT -3*7");
    md(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "MULTU max^2");
    md(0, 3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "DIV -7/2");
    md(0, 3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "DIV 7/-2");
    md(0, 3'd4, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, "DIVU 7/0");
    md(0, 3'd3, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, "DIV -5/0");
    md(0, 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "DIV MIN/-1");

    hi_keep = hi32;
    issue(0, 3'd6, 32'h0000ABCD, 32'h0, s);
    chk("MTLO LO", lo32, 32'h0000ABCD);
    chk("MTLO HI kept", hi32, hi_keep);
    chk("MTLO busy", {31'h0, busy32}, 32'd0);
    issue(0, 3'd5, 32'h00005555, 32'h0, s);
    chk("MTHI HI", hi32, 32'h00005555);
    chk("MTHI busy", {31'h0, busy32}, 32'd0);

    issue(0, 3'd1, 32'h00012345, 32'h100, s);
    e.name = "MULT under interference"; e.hi = 32'h0; e.lo = 32'h01234500; e.start = s;
    q32.push_back(e);
    repeat (5) @(negedge clk);
    alu(0, 4'd0, 32'd1, 32'd2, 32'd3, 0, 0, "ADD while busy");
    issue(0, 3'd5, 32'h00001234, 32'h0, s);
    issue(0, 3'd1, 32'd2, 32'd2, s);
    chk("busy held", {31'h0, busy32}, 32'd1);
    chk("HI held during run", hi32, 32'h00005555);
    wait_idle(0, "interference");
    repeat (40) @(negedge clk);
    chk("no second op", {31'h0, busy32}, 32'd0);

    issue(0, 3'd3, 32'd100, 32'd7, s);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset busy", {31'h0, busy32}, 32'd0);
    chk("async reset HI", hi32, 32'd0);
    chk("async reset LO", lo32, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    md(0, 3'd4, 32'd100, 32'd7, 32'd2, 32'd14, "DIVU 100/7 after reset");

    md(1, 3'd1, 32'hFFFD, 32'd7,    32'hFFFF, 32'hFFEB, "w16 MULT -3*7");
    md(1, 3'd2, 32'hFFFF, 32'hFFFF, 32'hFFFE, 32'h0001, "w16 MULTU max^2");
    md(1, 3'd3, 32'hFFF9, 32'd2,    32'hFFFF, 32'hFFFD, "w16 DIV -7/2");
    md(1, 3'd4, 32'd100,  32'd7,    32'd2,    32'd14,   "w16 DIVU 100/7");
    md(1, 3'd3, 32'h8000, 32'hFFFF, 32'h0,    32'h8000, "w16 DIV MIN/-1");

    repeat (5) @(negedge clk);
    chk("w32 scoreboard drained", 32'(q32.size()), 32'd0);
    chk("w16 scoreboard drained", 32'(q16.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
